// File: rtl/fifo_if.sv
// fifo_if: write/read handshake, status and error bundle for fifo_sync_param
interface fifo_if #(parameter int WIDTH = 8, parameter int DEPTH = 1024);
  logic wr_en, rd_en, err_clr;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with fill flags, sticky errors and optional FWFT read
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = 1020,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input logic   clk,
  input logic   rst,
  fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_N   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_N   = (AW+1)'(AE_LEVEL);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic wr_acc, rd_acc;
  assign bus.count        = cnt;
  assign bus.empty        = cnt == '0;
  assign bus.full         = cnt == FULL_N;
  assign bus.almost_full  = cnt >= AF_N;
  assign bus.almost_empty = cnt <= AE_N;
  // a full FIFO still takes a push when a pop frees a slot in the same cycle
  assign rd_acc = bus.rd_en & ~bus.empty;
  assign wr_acc = bus.wr_en & (~bus.full | rd_acc);
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      cnt           <= cnt + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      bus.overflow  <= (bus.wr_en & ~wr_acc) | (bus.overflow & ~bus.err_clr);
      bus.underflow <= (bus.rd_en & ~rd_acc) | (bus.underflow & ~bus.err_clr);
    end
  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data  = mem[rd_ptr];
      assign bus.rd_valid = ~bus.empty;
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          bus.rd_data  <= '0;
          bus.rd_valid <= 1'b0;
        end else begin
          bus.rd_valid <= rd_acc;
          if (rd_acc) bus.rd_data <= mem[rd_ptr];
        end
    end
  endgenerate
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of registered-read and FWFT FIFO instances
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  fifo_if #(.WIDTH(8), .DEPTH(16)) b0 ();
  fifo_if #(.WIDTH(8), .DEPTH(16)) b1 ();
  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic push(input logic [7:0] d);
    b0.wr_en = 1'b1;
    b0.wr_data = d;
    tick();
    b0.wr_en = 1'b0;
  endtask
  initial begin
    b0.wr_en = 0; b0.rd_en = 0; b0.err_clr = 0; b0.wr_data = 0;
    b1.wr_en = 0; b1.rd_en = 0; b1.err_clr = 0; b1.wr_data = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_count", 32'(b0.count), 0);
    chk("rst_empty", 32'(b0.empty), 1);
    chk("rst_full", 32'(b0.full), 0);
    chk("rst_ae", 32'(b0.almost_empty), 1);
    chk("rst_af", 32'(b0.almost_full), 0);
    chk("rst_rd_data", 32'(b0.rd_data), 0);
    chk("rst_rd_valid", 32'(b0.rd_valid), 0);
    chk("rst_ovf", 32'(b0.overflow), 0);
    chk("rst_unf", 32'(b0.underflow), 0);
    // async reset mid-stream
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    chk("t1_count5", 32'(b0.count), 5);
    chk("t1_ae_off", 32'(b0.almost_empty), 0);
    b0.rd_en = 1'b1;
    tick();
    b0.rd_en = 1'b0;
    chk("t1_pop_valid", 32'(b0.rd_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_count", 32'(b0.count), 0);
    chk("t1_async_empty", 32'(b0.empty), 1);
    chk("t1_async_valid", 32'(b0.rd_valid), 0);
    tick();
    rst = 1'b0;
    b0.rd_en = 1'b1;
    tick();
    b0.rd_en = 1'b0;
    chk("t1_underflow", 32'(b0.underflow), 1);
    chk("t1_unf_valid", 32'(b0.rd_valid), 0);
    b0.err_clr = 1'b1;
    tick();
    b0.err_clr = 1'b0;
    chk("t1_unf_clr", 32'(b0.underflow), 0);
    // fill / drain
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("t2_af", 32'(b0.almost_full), 32'(i + 1 >= 14));
    end
    chk("t2_full", 32'(b0.full), 1);
    chk("t2_count16", 32'(b0.count), 16);
    for (int i = 0; i < 16; i++) begin
      b0.rd_en = 1'b1;
      tick();
      chk("t2_rd_data", 32'(b0.rd_data), i);
      chk("t2_rd_valid", 32'(b0.rd_valid), 1);
    end
    b0.rd_en = 1'b0;
    chk("t2_empty", 32'(b0.empty), 1);
    tick();
    chk("t2_valid_drop", 32'(b0.rd_valid), 0);
    chk("t2_data_hold", 32'(b0.rd_data), 8'h0F);
    // overflow
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push(8'hAA);
    chk("t3_overflow", 32'(b0.overflow), 1);
    chk("t3_count", 32'(b0.count), 16);
    b0.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t3_drain", 32'(b0.rd_data), 8'h20 + i);
    end
    b0.err_clr = 1'b1;
    tick();
    chk("t3_set_wins", 32'(b0.underflow), 1);
    b0.rd_en = 1'b0;
    tick();
    b0.err_clr = 1'b0;
    chk("t3_ovf_clr", 32'(b0.overflow), 0);
    chk("t3_unf_clr", 32'(b0.underflow), 0);
    // simultaneous push/pop at full and at empty
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    b0.wr_en = 1'b1; b0.rd_en = 1'b1; b0.wr_data = 8'hBB;
    tick();
    b0.wr_en = 1'b0;
    chk("t4_full_count", 32'(b0.count), 16);
    chk("t4_full_pop", 32'(b0.rd_data), 8'h30);
    chk("t4_no_ovf", 32'(b0.overflow), 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("t4_drain", 32'(b0.rd_data), 8'h30 + i);
    end
    tick();
    chk("t4_tail", 32'(b0.rd_data), 8'hBB);
    chk("t4_empty", 32'(b0.empty), 1);
    b0.wr_en = 1'b1; b0.wr_data = 8'hCC;
    tick();
    b0.wr_en = 1'b0;
    chk("t4_empty_count", 32'(b0.count), 1);
    chk("t4_empty_unf", 32'(b0.underflow), 1);
    chk("t4_empty_valid", 32'(b0.rd_valid), 0);
    b0.err_clr = 1'b1;
    tick();
    b0.rd_en = 1'b0; b0.err_clr = 1'b0;
    chk("t4_cc", 32'(b0.rd_data), 8'hCC);
    chk("t4_unf_clr", 32'(b0.underflow), 0);
    chk("t4_count0", 32'(b0.count), 0);
    // wrap-around with interleaved traffic, fill kept between 3 and 12
    for (int k = 0; k < 40; k++) begin
      b0.wr_en = 1'b1;
      b0.wr_data = 8'(8'h40 + k);
      b0.rd_en = k >= 3 && k % 4 != 0;
      if (b0.rd_en) exp_d = q.pop_front();
      q.push_back(b0.wr_data);
      tick();
      if (b0.rd_en) chk("t5_order", 32'(b0.rd_data), 32'(exp_d));
    end
    b0.wr_en = 1'b0;
    b0.rd_en = 1'b0;
    chk("t5_count12", 32'(b0.count), 12);
    b0.rd_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_d = q.pop_front();
      tick();
      chk("t5_drain", 32'(b0.rd_data), 32'(exp_d));
    end
    b0.rd_en = 1'b0;
    chk("t5_empty", 32'(b0.empty), 1);
    chk("t5_no_unf", 32'(b0.underflow), 0);
    // first-word-fall-through instance
    chk("t6_idle_valid", 32'(b1.rd_valid), 0);
    b1.wr_en = 1'b1; b1.wr_data = 8'h5A;
    tick();
    b1.wr_en = 1'b0;
    chk("t6_valid", 32'(b1.rd_valid), 1);
    chk("t6_data", 32'(b1.rd_data), 8'h5A);
    b1.rd_en = 1'b1;
    tick();
    b1.rd_en = 1'b0;
    chk("t6_empty", 32'(b1.empty), 1);
    chk("t6_valid_off", 32'(b1.rd_valid), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
